// File: rtl/dmem_responder_if.sv
// ============================================================================
// dmem_responder_if : LSU <-> data-memory request/response bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder : single-outstanding data-memory responder, fixed latency,
//                  byte-lane stores, right-justified loads, alignment errors
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int         c_DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam state_t c_AFTER_ACCEPT = (LATENCY > 1) ? S_WAIT : S_RESP;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic [31:0]           r_mem [c_DEPTH];

  logic                  w_accept;
  logic                  w_err;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [1:0]            w_off;
  logic [3:0]            w_be;
  logic [31:0]           w_wlane;
  logic [31:0]           w_rd_word;
  logic [31:0]           w_rd_shift;
  logic [31:0]           w_load_data;
  logic                  w_req_ready;
  logic                  w_resp_valid;

  // Upper address bits are intentionally ignored so the memory wraps.
  wire w_unused = &{1'b0, bus.req_addr[31:DEPTH_LOG2+2]};

  assign w_idx      = bus.req_addr[DEPTH_LOG2+1:2];
  assign w_off      = bus.req_addr[1:0];
  assign w_accept   = (r_state == S_IDLE) && bus.req_valid;
  assign w_rd_word  = r_mem[w_idx];
  assign w_rd_shift = w_rd_word >> {w_off, 3'b000};

  always_comb begin
    w_err       = 1'b1;
    w_be        = 4'b0000;
    w_wlane     = 32'h0;
    w_load_data = 32'h0;
    case (bus.req_size)
      2'b00: begin
        w_err       = 1'b0;
        w_be        = 4'b0001 << w_off;
        w_wlane     = {4{bus.req_wdata[7:0]}};
        w_load_data = {24'h0, w_rd_shift[7:0]};
      end
      2'b01: begin
        w_err       = w_off[0];
        w_be        = w_off[1] ? 4'b1100 : 4'b0011;
        w_wlane     = {2{bus.req_wdata[15:0]}};
        w_load_data = {16'h0, w_rd_shift[15:0]};
      end
      2'b10: begin
        w_err       = (w_off != 2'b00);
        w_be        = 4'b1111;
        w_wlane     = bus.req_wdata;
        w_load_data = w_rd_shift;
      end
      default: begin
        w_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          w_state_nxt = c_AFTER_ACCEPT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_resp_valid = 1'b1;
        if (bus.resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= c_CNT_INIT;
      r_err   <= w_err;
      r_rdata <= (!w_err && !bus.req_we) ? w_load_data : 32'h0;
    end else if (r_state == S_WAIT) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  // RAM array carries no reset; lanes commit on the accepting edge.
  always_ff @(posedge clk) begin
    if (w_accept && !w_err && bus.req_we) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) begin
          r_mem[w_idx][8*k +: 8] <= w_wlane[8*k +: 8];
        end
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

endmodule

`default_nettype wire
